// File: rtl/periph_pkg.sv
// rtl/periph_pkg.sv - shared constants and types for the memory-mapped peripheral block
package periph_pkg;

  localparam logic [26:0] PERIPH_BASE = 27'h200_0000;

  localparam logic [2:0] OFF_TH   = 3'd0;
  localparam logic [2:0] OFF_TL   = 3'd1;
  localparam logic [2:0] OFF_TCON = 3'd2;
  localparam logic [2:0] OFF_LED  = 3'd3;
  localparam logic [2:0] OFF_DIGI = 3'd4;
  localparam logic [2:0] OFF_TICK = 3'd5;
  localparam logic [2:0] OFF_UTXD = 3'd6;
  localparam logic [2:0] OFF_UCON = 3'd7;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - 8N1 serial transmitter: baud counter, bit index, shift register, FSM
module uart_tx_core
  import periph_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          busy_q;
  logic          baud_done;

  assign baud_done = (baud_q == BAUD_LAST);
  assign busy      = busy_q;
  assign tx        = tx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= UART_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      if (state_q != UART_IDLE) begin
        baud_q <= baud_done ? '0 : baud_q + 1'b1;
      end
      case (state_q)
        UART_IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          // start is ignored while busy, so a mid-frame byte never touches shift_q
          if (start) begin
            shift_q <= data;
            state_q <= UART_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        UART_START: begin
          if (baud_done) begin
            state_q <= UART_DATA;
            bit_q   <= 3'd0;
            tx_q    <= shift_q[0];
          end
        end
        UART_DATA: begin
          if (baud_done) begin
            if (bit_q == 3'd7) begin
              state_q <= UART_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end
        end
        UART_STOP: begin
          if (baud_done) begin
            state_q <= UART_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= UART_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/peripheral_bus.sv
// rtl/peripheral_bus.sv - MEM-stage peripheral responder: decode, timer, LED/7-seg, systick, UART
module peripheral_bus
  import periph_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        irq,
  output logic [7:0]  leds,
  output logic [11:0] digi,
  output logic        uart_tx
);

  logic [31:0] th_q, tl_q, tl_d, systick_q;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, txd_q;
  logic [11:0] digi_q;
  logic        irq_q, irq_d, start_q, uart_busy;
  logic        hit, wr, ovf;
  logic [2:0]  idx;
  logic        addr_unused;

  assign hit         = (Address[31:5] == PERIPH_BASE);
  assign idx         = Address[4:2];
  assign wr          = MemWrite & hit;
  assign addr_unused = ^Address[1:0];
  assign ovf         = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);

  // CPU writes are applied last so they win over the timer's own update
  always_comb begin
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (tcon_q[TCON_EN]) tl_d = ovf ? th_q : tl_q + 32'd1;
    if (ovf && tcon_q[TCON_IE]) tcon_d[TCON_IS] = 1'b1;
    if (wr && idx == OFF_TL) tl_d = Write_data;
    if (wr && idx == OFF_TCON) tcon_d = Write_data[2:0];
    irq_d = tcon_q[TCON_IE] & tcon_q[TCON_IS];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= 32'd0;
      tl_q      <= 32'd0;
      tcon_q    <= 3'd0;
      led_q     <= 8'd0;
      digi_q    <= 12'd0;
      systick_q <= 32'd0;
      txd_q     <= 8'd0;
      start_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      irq_q     <= irq_d;
      systick_q <= systick_q + 32'd1;
      start_q   <= wr && (idx == OFF_UTXD) && !uart_busy;
      if (wr && idx == OFF_TH)   th_q   <= Write_data;
      if (wr && idx == OFF_LED)  led_q  <= Write_data[7:0];
      if (wr && idx == OFF_DIGI) digi_q <= Write_data[11:0];
      if (wr && idx == OFF_UTXD) txd_q  <= Write_data[7:0];
    end
  end

  uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk  (clk),
    .reset(reset),
    .start(start_q),
    .data (txd_q),
    .busy (uart_busy),
    .tx   (uart_tx)
  );

  always_comb begin
    Read_data = 32'd0;
    if (MemRead && hit) begin
      case (idx)
        OFF_TH:   Read_data = th_q;
        OFF_TL:   Read_data = tl_q;
        OFF_TCON: Read_data = {29'd0, tcon_q};
        OFF_LED:  Read_data = {24'd0, led_q};
        OFF_DIGI: Read_data = {20'd0, digi_q};
        OFF_TICK: Read_data = systick_q;
        OFF_UTXD: Read_data = {24'd0, txd_q};
        default:  Read_data = {31'd0, uart_busy};
      endcase
    end
  end

  assign irq  = irq_q;
  assign leds = led_q;
  assign digi = digi_q;

endmodule

// File: tb/tb_peripheral_bus.sv
// tb/tb_peripheral_bus.sv - self-checking bench for peripheral_bus (vector table + scoreboard)
module tb_peripheral_bus;
  import periph_pkg::*;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Address = 32'd0;
  logic [31:0] Write_data = 32'd0;
  logic [31:0] Read_data;
  logic        irq;
  logic [7:0]  leds;
  logic [11:0] digi;
  logic        uart_tx;

  peripheral_bus #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .Write_data(Write_data),
    .Read_data (Read_data),
    .irq       (irq),
    .leds      (leds),
    .digi      (digi),
    .uart_tx   (uart_tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  localparam logic [1:0] OP_RD = 2'd0, OP_WR = 2'd1, OP_NOSTROBE = 2'd2;

  int          num_checks = 0;
  int          num_errors = 0;
  logic [31:0] sb_q[$];
  logic        tx_sb[$];
  vec_t        vecs[$];

  function automatic logic [31:0] ra(input logic [2:0] off);
    return {PERIPH_BASE, off, 2'b00};
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] e);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name, input logic [31:0] act);
    if (sb_q.size() == 0) begin
      num_checks++;
      num_errors++;
      $display("FAIL %s: got 0x%08h, expected scoreboard entry (queue empty)", name, act);
    end else begin
      check(name, act, sb_q.pop_front());
    end
  endtask

  // All tasks are entered and left just after a falling edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address = a; Write_data = d; MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Address = a; MemRead = 1'b1;
    #1;
    d = Read_data;
    MemRead = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    sb_q.push_back(exp);
    rd(a, d);
    sb_pop(name, d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    logic [9:0]  frame;
    int          low_cnt;

    // Power-up reset
    idle(3);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_leds", {24'd0, leds}, 32'd0);
    check("rst_digi", {20'd0, digi}, 32'd0);
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    rd_chk("rst_tick", ra(OFF_TICK), 32'd0);
    reset = 1'b0;
    rd_chk("rst_ucon", ra(OFF_UCON), 32'd0);
    rd_chk("rst_tcon", ra(OFF_TCON), 32'd0);

    // Register map / decode vectors
    vecs.push_back(mk(OP_WR, ra(OFF_TH), 32'h1234_5678, 32'd0));
    vecs.push_back(mk(OP_RD, ra(OFF_TH), 32'd0, 32'h1234_5678));
    vecs.push_back(mk(OP_WR, ra(OFF_TL), 32'h0000_0055, 32'd0));
    vecs.push_back(mk(OP_RD, ra(OFF_TL), 32'd0, 32'h0000_0055));
    vecs.push_back(mk(OP_WR, ra(OFF_LED), 32'h0000_01FF, 32'd0));
    vecs.push_back(mk(OP_RD, ra(OFF_LED), 32'd0, 32'h0000_00FF));
    vecs.push_back(mk(OP_RD, 32'h4000_000F, 32'd0, 32'h0000_00FF));
    vecs.push_back(mk(OP_WR, ra(OFF_DIGI), 32'hFFFF_FABC, 32'd0));
    vecs.push_back(mk(OP_RD, ra(OFF_DIGI), 32'd0, 32'h0000_0ABC));
    vecs.push_back(mk(OP_WR, 32'h4000_0020, 32'h0000_0000, 32'd0));
    vecs.push_back(mk(OP_RD, 32'h4000_0020, 32'd0, 32'h0000_0000));
    vecs.push_back(mk(OP_RD, ra(OFF_LED), 32'd0, 32'h0000_00FF));
    vecs.push_back(mk(OP_WR, 32'h3FFF_FFEC, 32'h0000_0000, 32'd0));
    vecs.push_back(mk(OP_RD, ra(OFF_LED), 32'd0, 32'h0000_00FF));
    vecs.push_back(mk(OP_WR, ra(OFF_UCON), 32'h0000_0001, 32'd0));
    vecs.push_back(mk(OP_RD, ra(OFF_UCON), 32'd0, 32'h0000_0000));
    vecs.push_back(mk(OP_NOSTROBE, ra(OFF_LED), 32'd0, 32'h0000_0000));

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_WR: wr(vecs[i].addr, vecs[i].data);
        OP_RD: rd_chk($sformatf("vec%0d_read", i), vecs[i].addr, vecs[i].exp);
        default: begin
          sb_q.push_back(vecs[i].exp);
          Address = vecs[i].addr; MemRead = 1'b0; MemWrite = 1'b0;
          #1;
          sb_pop($sformatf("vec%0d_nostrobe", i), Read_data);
        end
      endcase
    end
    check("leds_port", {24'd0, leds}, 32'h0000_00FF);
    check("digi_port", {20'd0, digi}, 32'h0000_0ABC);

    // SYSTICK spacing
    rd(ra(OFF_TICK), a);
    idle(5);
    rd(ra(OFF_TICK), b);
    check("systick_delta", b - a, 32'd5);

    // Timer reload and irq
    wr(ra(OFF_TH), 32'hFFFF_FFFD);
    wr(ra(OFF_TL), 32'hFFFF_FFFD);
    wr(ra(OFF_TCON), 32'h3);
    rd_chk("tl_t0", ra(OFF_TL), 32'hFFFF_FFFD);
    idle(1);
    rd_chk("tl_t1", ra(OFF_TL), 32'hFFFF_FFFE);
    idle(1);
    rd_chk("tl_t2", ra(OFF_TL), 32'hFFFF_FFFF);
    rd_chk("tcon_pre_ovf", ra(OFF_TCON), 32'h3);
    idle(1);
    rd_chk("tl_reload", ra(OFF_TL), 32'hFFFF_FFFD);
    rd_chk("tcon_ovf", ra(OFF_TCON), 32'h7);
    check("irq_same_edge", {31'd0, irq}, 32'd0);
    idle(1);
    check("irq_next_edge", {31'd0, irq}, 32'd1);
    wr(ra(OFF_TCON), 32'h3);
    check("irq_clear_edge", {31'd0, irq}, 32'd1);
    idle(1);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    wr(ra(OFF_TCON), 32'h0);
    idle(1);

    // Overflow coinciding with a TL write
    wr(ra(OFF_TH), 32'h0000_0100);
    wr(ra(OFF_TL), 32'hFFFF_FFFE);
    wr(ra(OFF_TCON), 32'h3);
    idle(1);
    wr(ra(OFF_TL), 32'h0000_0005);
    rd_chk("coll_tl", ra(OFF_TL), 32'h0000_0005);
    rd_chk("coll_tcon", ra(OFF_TCON), 32'h7);

    // Overflow coinciding with a TCON write
    wr(ra(OFF_TCON), 32'h0);
    wr(ra(OFF_TL), 32'hFFFF_FFFE);
    wr(ra(OFF_TCON), 32'h3);
    idle(1);
    wr(ra(OFF_TCON), 32'h3);
    rd_chk("coll2_tcon", ra(OFF_TCON), 32'h3);
    rd_chk("coll2_tl", ra(OFF_TL), 32'h0000_0100);
    idle(1);
    check("coll2_irq", {31'd0, irq}, 32'd0);
    wr(ra(OFF_TCON), 32'h0);

    // UART frame, with a dropped mid-frame write
    frame = {1'b1, 8'hA5, 1'b0};
    for (int bi = 0; bi < 10; bi++)
      for (int c = 0; c < CPB; c++) tx_sb.push_back(frame[bi]);
    wr(ra(OFF_UTXD), 32'h0000_00A5);
    check("tx_before_start", {31'd0, uart_tx}, 32'd1);
    rd_chk("busy_before_start", ra(OFF_UCON), 32'd0);
    for (int j = 1; j <= 10 * CPB; j++) begin
      if (j == 20) wr(ra(OFF_UTXD), 32'h0000_003C);
      else idle(1);
      if (tx_sb.size() == 0) begin
        num_checks++;
        num_errors++;
        $display("FAIL tx_cyc%0d: got %0b, expected scoreboard entry (queue empty)", j, uart_tx);
      end else begin
        check($sformatf("tx_cyc%0d", j), {31'd0, uart_tx}, {31'd0, tx_sb.pop_front()});
      end
      rd_chk($sformatf("busy_cyc%0d", j), ra(OFF_UCON), 32'd1);
    end
    rd_chk("txd_readback", ra(OFF_UTXD), 32'h0000_003C);
    idle(1);
    rd_chk("busy_done", ra(OFF_UCON), 32'd0);
    low_cnt = 0;
    for (int j = 0; j < 3 * CPB; j++) begin
      idle(1);
      if (uart_tx !== 1'b1) low_cnt++;
    end
    check("dropped_write_no_frame", low_cnt, 32'd0);

    // Reset in the middle of a frame
    wr(ra(OFF_TCON), 32'h6);
    wr(ra(OFF_LED), 32'h0000_005A);
    wr(ra(OFF_UTXD), 32'h0000_0000);
    idle(3);
    check("pre_rst_tx_low", {31'd0, uart_tx}, 32'd0);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_tx", {31'd0, uart_tx}, 32'd1);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    check("mid_rst_leds", {24'd0, leds}, 32'd0);
    check("mid_rst_digi", {20'd0, digi}, 32'd0);
    rd_chk("mid_rst_tick", ra(OFF_TICK), 32'd0);
    rd_chk("mid_rst_ucon", ra(OFF_UCON), 32'd0);
    rd_chk("mid_rst_th", ra(OFF_TH), 32'd0);
    idle(1);
    reset = 1'b0;
    low_cnt = 0;
    for (int j = 0; j < 3 * CPB; j++) begin
      idle(1);
      if (uart_tx !== 1'b1) low_cnt++;
    end
    check("frame_aborted", low_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
